// File: rtl/hps_reset_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// hps_reset_pkg
// Shared types and constants for the HPS reset sequencer.
//   state_t         : sequencer FSM states (idle, pulse in flight, guard gap)
//   REQ_COLD/WARM/DEBUG : bit positions of each request type in req/pending
//   priority_grant  : one-hot pick of the highest-priority active request
//   grant_to_index  : converts that one-hot grant into a request index
// ---------------------------------------------------------------------------
package hps_reset_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULSE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  localparam int unsigned NUM_REQ   = 3;
  localparam logic [1:0]  REQ_COLD  = 2'd0;
  localparam logic [1:0]  REQ_WARM  = 2'd1;
  localparam logic [1:0]  REQ_DEBUG = 2'd2;

  // Cold outranks warm, warm outranks debug; at most one bit is returned.
  function automatic logic [2:0] priority_grant(input logic [2:0] v);
    logic [2:0] g;
    g    = 3'b000;
    g[0] = v[0];
    g[1] = v[1] & ~v[0];
    g[2] = v[2] & ~v[1] & ~v[0];
    return g;
  endfunction

  // An all-zero grant maps to cold; callers only use the index when a grant exists.
  function automatic logic [1:0] grant_to_index(input logic [2:0] g);
    logic [1:0] idx;
    idx = REQ_COLD;
    if (g[1]) idx = REQ_WARM;
    if (g[2]) idx = REQ_DEBUG;
    return idx;
  endfunction

endpackage

// File: rtl/hps_reset_sequencer_if.sv
// ---------------------------------------------------------------------------
// hps_reset_sequencer_if
// Bundles the request inputs and reset-request outputs of the sequencer.
//   req           : level requests, [0]=cold [1]=warm [2]=debug
//   cold_reset_n  : to f2h_cold_reset_req_reset_n, active-low
//   warm_reset_n  : to f2h_warm_reset_req_reset_n, active-low
//   debug_reset_n : to f2h_debug_reset_req_reset_n, active-low
//   busy          : high while a pulse or guard gap is in progress
//   pending       : latched requests not yet served (same order as req)
// master = sequencer side, slave = request source / HPS side.
// ---------------------------------------------------------------------------
interface hps_reset_sequencer_if;
  import hps_reset_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               cold_reset_n;
  logic               warm_reset_n;
  logic               debug_reset_n;
  logic               busy;
  logic [NUM_REQ-1:0] pending;

  modport master (
    input  req,
    output cold_reset_n,
    output warm_reset_n,
    output debug_reset_n,
    output busy,
    output pending
  );

  modport slave (
    output req,
    input  cold_reset_n,
    input  warm_reset_n,
    input  debug_reset_n,
    input  busy,
    input  pending
  );

endinterface

// File: rtl/hps_reset_sequencer_capture.sv
// ---------------------------------------------------------------------------
// reset_req_capture
// Per-bit rising-edge detector with a sticky pending latch.
//   i_clk     : system clock
//   i_rst     : synchronous active-high reset
//   i_req     : level request inputs
//   i_clear   : one-hot clear of the request(s) being served this cycle
//   o_edge    : combinational rising edge (req & ~previous req)
//   o_pending : registered requests seen but not yet served
// ---------------------------------------------------------------------------
module reset_req_capture #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_req,
  input  logic [WIDTH-1:0] i_clear,
  output logic [WIDTH-1:0] o_edge,
  output logic [WIDTH-1:0] o_pending
);

  logic [WIDTH-1:0] r_reqQ;
  logic [WIDTH-1:0] r_pending;

  // Because r_reqQ resets to zero, a request held high through reset
  // shows up as a fresh edge on the first cycle after reset.
  assign o_edge    = i_req & ~r_reqQ;
  assign o_pending = r_pending;

  // Remember the previous request level and accumulate edges into the
  // pending latch. A clear on the same cycle as an edge wins, so a request
  // that is served immediately never appears as pending; repeated edges
  // on an already-pending bit simply collapse into the one latched bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_reqQ    <= '0;
      r_pending <= '0;
    end else begin
      r_reqQ    <= i_req;
      r_pending <= (r_pending | o_edge) & ~i_clear;
    end
  end

endmodule

// File: rtl/hps_reset_sequencer.sv
// ---------------------------------------------------------------------------
// hps_reset_sequencer
// Arbitrates cold/warm/debug HPS reset requests and drives the f2h reset
// request lines with fixed-width, non-overlapping active-low pulses,
// separated by a guard gap of HOLDOFF cycles.
//   i_clk : system clock
//   i_rst : synchronous active-high reset
//   bus   : hps_reset_sequencer_if.master (req in; reset_n/busy/pending out)
// Parameters: COLD_PULSE, WARM_PULSE, DEBUG_PULSE, HOLDOFF (cycles, >=1),
//             CNT_WIDTH (timer width, must hold the largest of them).
// ---------------------------------------------------------------------------
module hps_reset_sequencer
  import hps_reset_pkg::*;
#(
  parameter int unsigned COLD_PULSE  = 6,
  parameter int unsigned WARM_PULSE  = 2,
  parameter int unsigned DEBUG_PULSE = 32,
  parameter int unsigned HOLDOFF     = 4,
  parameter int unsigned CNT_WIDTH   = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  hps_reset_sequencer_if.master bus
);

  localparam logic [CNT_WIDTH-1:0] C_COLD_LOAD    = CNT_WIDTH'(COLD_PULSE - 1);
  localparam logic [CNT_WIDTH-1:0] C_WARM_LOAD    = CNT_WIDTH'(WARM_PULSE - 1);
  localparam logic [CNT_WIDTH-1:0] C_DEBUG_LOAD   = CNT_WIDTH'(DEBUG_PULSE - 1);
  localparam logic [CNT_WIDTH-1:0] C_HOLDOFF_LOAD = CNT_WIDTH'(HOLDOFF - 1);

  state_t               r_state;
  state_t               w_nextState;
  logic [CNT_WIDTH-1:0] r_timer;
  logic [CNT_WIDTH-1:0] w_nextTimer;
  logic [1:0]           r_sel;
  logic [1:0]           w_nextSel;

  logic                 r_coldResetN;
  logic                 r_warmResetN;
  logic                 r_debugResetN;
  logic                 r_busy;
  logic                 w_nextColdResetN;
  logic                 w_nextWarmResetN;
  logic                 w_nextDebugResetN;
  logic                 w_nextBusy;

  logic [NUM_REQ-1:0]   w_edge;
  logic [NUM_REQ-1:0]   w_pending;
  logic [NUM_REQ-1:0]   w_service;
  logic [NUM_REQ-1:0]   w_grant;
  logic [NUM_REQ-1:0]   w_clear;
  logic [1:0]           w_grantIdx;
  logic [CNT_WIDTH-1:0] w_loadValue;
  logic                 w_start;

  reset_req_capture #(
    .WIDTH(NUM_REQ)
  ) u_capture (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_req     (bus.req),
    .i_clear   (w_clear),
    .o_edge    (w_edge),
    .o_pending (w_pending)
  );

  // A fresh edge is as good as a latched request, so both feed arbitration
  // and a request arriving while idle starts its pulse without a detour
  // through pending.
  assign w_service  = w_edge | w_pending;
  assign w_grant    = priority_grant(w_service);
  assign w_grantIdx = grant_to_index(w_grant);

  assign bus.cold_reset_n  = r_coldResetN;
  assign bus.warm_reset_n  = r_warmResetN;
  assign bus.debug_reset_n = r_debugResetN;
  assign bus.busy          = r_busy;
  assign bus.pending       = w_pending;

  // State register plus the shared down-counter, the selected request type
  // and the registered reset-request outputs. Reset returns everything to
  // idle with all lines deasserted, which also truncates a pulse in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_timer       <= '0;
      r_sel         <= REQ_COLD;
      r_coldResetN  <= 1'b1;
      r_warmResetN  <= 1'b1;
      r_debugResetN <= 1'b1;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_nextState;
      r_timer       <= w_nextTimer;
      r_sel         <= w_nextSel;
      r_coldResetN  <= w_nextColdResetN;
      r_warmResetN  <= w_nextWarmResetN;
      r_debugResetN <= w_nextDebugResetN;
      r_busy        <= w_nextBusy;
    end
  end

  // Next-state logic. A pulse may start from idle, from the last cycle of
  // the guard gap (so back-to-back pulses are spaced exactly width+HOLDOFF),
  // or mid-pulse when a cold edge preempts a warm or debug pulse. The
  // preempted request is simply dropped: its pending bit was already cleared
  // when it started, and a cold reset supersedes it anyway. Because cold is
  // the top priority, the normal grant always picks cold on a preemption.
  always_comb begin
    w_nextState = r_state;
    w_nextTimer = r_timer;
    w_nextSel   = r_sel;
    w_clear     = '0;
    w_start     = 1'b0;
    w_loadValue = C_DEBUG_LOAD;

    unique case (w_grantIdx)
      REQ_COLD: w_loadValue = C_COLD_LOAD;
      REQ_WARM: w_loadValue = C_WARM_LOAD;
      default:  w_loadValue = C_DEBUG_LOAD;
    endcase

    unique case (r_state)
      ST_IDLE: begin
        if (|w_service) begin
          w_start = 1'b1;
        end
      end
      ST_PULSE: begin
        if (w_edge[REQ_COLD] && (r_sel != REQ_COLD)) begin
          w_start = 1'b1;
        end else if (r_timer == '0) begin
          w_nextState = ST_HOLDOFF;
          w_nextTimer = C_HOLDOFF_LOAD;
        end else begin
          w_nextTimer = r_timer - 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (r_timer == '0) begin
          if (|w_service) begin
            w_start = 1'b1;
          end else begin
            w_nextState = ST_IDLE;
          end
        end else begin
          w_nextTimer = r_timer - 1'b1;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
        w_nextTimer = '0;
      end
    endcase

    if (w_start) begin
      w_nextState = ST_PULSE;
      w_nextTimer = w_loadValue;
      w_nextSel   = w_grantIdx;
      w_clear     = w_grant;
    end
  end

  // Output decode from the next state so the registered lines change on the
  // same edge as the state. Only the selected line can be low, and only in
  // the pulse state, so the three outputs can never overlap.
  always_comb begin
    w_nextColdResetN  = 1'b1;
    w_nextWarmResetN  = 1'b1;
    w_nextDebugResetN = 1'b1;
    w_nextBusy        = (w_nextState != ST_IDLE);
    if (w_nextState == ST_PULSE) begin
      w_nextColdResetN  = (w_nextSel != REQ_COLD);
      w_nextWarmResetN  = (w_nextSel != REQ_WARM);
      w_nextDebugResetN = (w_nextSel != REQ_DEBUG);
    end
  end

endmodule

// File: tb/tb_hps_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_hps_reset_sequencer
// Directed bench for hps_reset_sequencer with default parameters
// (cold 6, warm 2, debug 32, holdoff 4). Inputs change on the falling edge;
// outputs are sampled on the falling edge. Cycle c of a scenario is the
// c-th falling edge after the scenario drove its first request.
// Observed vector layout: {cold_n, warm_n, debug_n, busy, pending[2:0]}.
// ---------------------------------------------------------------------------
module tb_hps_reset_sequencer;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  hps_reset_sequencer_if bus ();

  hps_reset_sequencer #(
    .COLD_PULSE  (6),
    .WARM_PULSE  (2),
    .DEBUG_PULSE (32),
    .HOLDOFF     (4),
    .CNT_WIDTH   (6)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Free-running 100 MHz-style clock for the bench.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reset held, then released with no requests: everything stays quiet.
  task automatic test_reset();
    logic [6:0] obs;
    rst     = 1'b1;
    bus.req = 3'b000;
    repeat (2) @(negedge clk);
    obs = {bus.cold_reset_n, bus.warm_reset_n, bus.debug_reset_n, bus.busy, bus.pending};
    vectors++;
    if (obs !== 7'b111_0_000) begin
      miscompares++;
      $display("[TB] FAIL reset_held: got %b expected %b", obs, 7'b111_0_000);
    end
    rst = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      obs = {bus.cold_reset_n, bus.warm_reset_n, bus.debug_reset_n, bus.busy, bus.pending};
      vectors++;
      if (obs !== 7'b111_0_000) begin
        miscompares++;
        $display("[TB] FAIL reset_idle c%0d: got %b expected %b", c, obs, 7'b111_0_000);
      end
    end
  endtask

  // One warm edge: low for 2 cycles, busy for 2+4, idle afterwards.
  task automatic test_single_warm();
    logic [6:0] obs;
    logic [6:0] exp;
    bus.req = 3'b010;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      exp = {1'b1, !(c >= 1 && c <= 2), 1'b1, (c >= 1 && c <= 6), 3'b000};
      obs = {bus.cold_reset_n, bus.warm_reset_n, bus.debug_reset_n, bus.busy, bus.pending};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("[TB] FAIL single_warm c%0d: got %b expected %b", c, obs, exp);
      end
    end
    bus.req = 3'b000;
    repeat (3) @(negedge clk);
  endtask

  // All three rise together: cold, then warm, then debug, each separated
  // by a 4-cycle gap, with pending draining 110 -> 100 -> 000.
  task automatic test_back_to_back();
    logic [6:0] obs;
    logic [6:0] exp;
    logic [2:0] expPend;
    bus.req = 3'b111;
    for (int c = 1; c <= 56; c++) begin
      @(negedge clk);
      if (c <= 10)      expPend = 3'b110;
      else if (c <= 16) expPend = 3'b100;
      else              expPend = 3'b000;
      exp = {!(c >= 1 && c <= 6), !(c >= 11 && c <= 12), !(c >= 17 && c <= 48),
             (c >= 1 && c <= 52), expPend};
      obs = {bus.cold_reset_n, bus.warm_reset_n, bus.debug_reset_n, bus.busy, bus.pending};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("[TB] FAIL back_to_back c%0d: got %b expected %b", c, obs, exp);
      end
    end
    bus.req = 3'b000;
    repeat (3) @(negedge clk);
  endtask

  // Debug pulse preempted by a cold edge; debug is not repeated afterwards.
  task automatic test_preempt();
    logic [6:0] obs;
    logic [6:0] exp;
    bus.req = 3'b100;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      exp = {!(c >= 6 && c <= 11), 1'b1, !(c >= 1 && c <= 5), (c >= 1 && c <= 15), 3'b000};
      obs = {bus.cold_reset_n, bus.warm_reset_n, bus.debug_reset_n, bus.busy, bus.pending};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("[TB] FAIL preempt c%0d: got %b expected %b", c, obs, exp);
      end
      if (c == 5) bus.req = 3'b101;
    end
    bus.req = 3'b000;
    repeat (3) @(negedge clk);
  endtask

  // Two warm edges during the guard gap collapse into one extra pulse
  // that starts right after the gap ends.
  task automatic test_holdoff_warm();
    logic [6:0] obs;
    logic [6:0] exp;
    bus.req = 3'b010;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      exp = {1'b1, !((c >= 1 && c <= 2) || (c >= 7 && c <= 8)), 1'b1,
             (c >= 1 && c <= 12), ((c == 5 || c == 6) ? 3'b010 : 3'b000)};
      obs = {bus.cold_reset_n, bus.warm_reset_n, bus.debug_reset_n, bus.busy, bus.pending};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("[TB] FAIL holdoff_warm c%0d: got %b expected %b", c, obs, exp);
      end
      if (c == 3) bus.req = 3'b000;
      if (c == 4) bus.req = 3'b010;
      if (c == 5) bus.req = 3'b000;
      if (c == 6) bus.req = 3'b010;
    end
    bus.req = 3'b000;
    repeat (3) @(negedge clk);
  endtask

  // Reset in the middle of a debug pulse with a warm request pending:
  // everything clears, and the debug request still held high afterwards
  // produces exactly one fresh pulse.
  task automatic test_reset_mid_pulse();
    logic [6:0] obs;
    logic [6:0] exp;
    bus.req = 3'b100;
    for (int c = 1; c <= 46; c++) begin
      @(negedge clk);
      exp = {1'b1, 1'b1, !((c >= 1 && c <= 5) || (c >= 7 && c <= 38)),
             ((c >= 1 && c <= 5) || (c >= 7 && c <= 42)),
             ((c == 4 || c == 5) ? 3'b010 : 3'b000)};
      obs = {bus.cold_reset_n, bus.warm_reset_n, bus.debug_reset_n, bus.busy, bus.pending};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("[TB] FAIL reset_mid_pulse c%0d: got %b expected %b", c, obs, exp);
      end
      if (c == 3) bus.req = 3'b110;
      if (c == 5) begin
        rst     = 1'b1;
        bus.req = 3'b100;
      end
      if (c == 6) rst = 1'b0;
    end
    bus.req = 3'b000;
    repeat (3) @(negedge clk);
  endtask

  // Scenario sequence and summary.
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus.req     = 3'b000;
    test_reset();
    test_single_warm();
    test_back_to_back();
    test_preempt();
    test_holdoff_warm();
    test_reset_mid_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hps_reset_sequencer.md
# hps_reset_sequencer

Arbitrates and sequences HPS reset requests (cold, warm, debug) raised by FPGA-side logic, and drives the HPS f2h reset-request inputs with fixed-width, non-overlapping pulses. It sits between the request sources (HPS-generated `hps_reset_req[2:0]` and debounced push-buttons) and the `soc_system` `hps_0_f2h_*_reset_req_reset_n` ports. It guarantees a single reset type in flight, priority cold > warm > debug, and a guard gap between consecutive pulses.

## Interface
- `COLD_PULSE`, 6: cold pulse width in clk cycles, ≥1
- `WARM_PULSE`, 2: warm pulse width in clk cycles, ≥1
- `DEBUG_PULSE`, 32: debug pulse width in clk cycles, ≥1
- `HOLDOFF`, 4: minimum low cycles between consecutive pulses, ≥1
- `CNT_WIDTH`, 6: timer width; 2^CNT_WIDTH > max(all pulse widths, HOLDOFF)

- `clk`  in  1  system clock (FPGA_CLK1_50 domain)
- `rst`  in  1  synchronous, active-high reset
- `req`  in  3  level requests, [0]=cold [1]=warm [2]=debug; synchronous to clk; rising edge = one request
- `cold_reset_n`  out  1  to f2h_cold_reset_req_reset_n, active-low
- `warm_reset_n`  out  1  to f2h_warm_reset_req_reset_n, active-low
- `debug_reset_n`  out  1  to f2h_debug_reset_req_reset_n, active-low
- `busy`  out  1  high in PULSE or HOLDOFF
- `pending`  out  3  latched, not-yet-served requests (same bit order as req)

## Operation
- Edge capture per bit: `req_q` registered; edge = `req & ~req_q`. Edge sets `pending[i]`; cleared on the cycle its pulse starts. Repeated edges while pending collapse to one.
- `req_q` resets to 0; a request held high through reset counts as an edge on the first cycle after reset.
- FSM states: IDLE, PULSE, HOLDOFF.
  - IDLE: if any (edge | pending) → PULSE, select highest priority (cold > warm > debug), load timer with that width − 1, clear that pending bit.
  - PULSE: selected output low; timer decrements; at 0 → HOLDOFF, timer = HOLDOFF − 1.
  - HOLDOFF: all outputs high; at timer 0 → IDLE.
- Preemption: cold edge during a warm or debug PULSE aborts it immediately: next cycle cold pulse starts with full COLD_PULSE, the aborted type stays pending? No — aborted warm/debug is discarded (cold reset supersedes). Warm/debug edges never preempt.
- Cold edge during HOLDOFF: latched, served after HOLDOFF completes.
- Simultaneous edges: highest priority served, others latched pending.
- Outputs are registered; at most one of the three is low in any cycle.

## Timing
- Reset: FSM=IDLE, timer=0, `pending`=0, `req_q`=0; all `*_reset_n`=1, `busy`=0 on the cycle after `rst` sampled high. Reset mid-pulse ends the pulse that cycle.
- Latency: `req[i]` first sampled high at edge k → its output low from edge k+1 (if IDLE), `busy` high from k+1.
- Pulse width exactly the parameter value in cycles; then exactly HOLDOFF cycles all-high before any next pulse.
- Back-to-back requests: minimum period between pulse starts = width + HOLDOFF.
- `pending` bit visible high from edge k+1 when not served immediately.

## Structure
- Package `hps_reset_pkg`: state enum (IDLE, PULSE, HOLDOFF), request index constants REQ_COLD=0, REQ_WARM=1, REQ_DEBUG=2.
- One sub-module natural: `reset_req_capture` (per-bit edge detect + pending latch, with clear input), instantiated ×3 or width-parameterized.
- Top holds FSM, shared down-counter, priority encoder, output registers.

## Test plan
- Reset release with req=000 → all outputs 1, busy 0, pending 000 indefinitely.
- Single warm edge at cycle 10 → warm_reset_n low cycles 11–12, busy high cycles 11–16, idle at 17.
- Cold+warm+debug rise same cycle 10 → cold low 11–16, HOLDOFF 17–20, warm low 21–22, HOLDOFF 23–26, debug low 27–58; pending 110→100→000.
- Debug edge at 10, cold edge at 15 → debug low 11–15, cold low 16–21, debug not repeated.
- Warm edge during HOLDOFF, plus second warm edge before service → exactly one extra warm pulse after HOLDOFF.
- rst asserted mid debug pulse → next cycle all outputs 1, pending 0; req held high across reset → one pulse after release.
